baud_tick_gen: RTL and testbench

BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

---
 rtl/baud_tick_gen_pkg.sv | 20 ++
 rtl/baud_prescaler.sv | 68 ++++++
 rtl/baud_tick_gen.sv | 83 ++++++++
 tb/tb_baud_tick_gen.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/baud_tick_gen_pkg.sv
// Shared constants for the baud tick generator: default clocking, divisor
// calculation and the smallest divisor a runtime write may install.
package baud_tick_gen_pkg;

    localparam int unsigned CLK_HZ_DEF     = 100_000_000;
    localparam int unsigned BAUD_DEF       = 9600;
    localparam int unsigned OVERSAMPLE_DEF = 16;
    localparam int unsigned DIV_W_DEF      = 16;
    localparam int unsigned MIN_DIV        = 2;

    // Clock cycles per oversample tick, truncated toward zero.
    function automatic int unsigned calc_div(
        input int unsigned clk_hz,
        input int unsigned baud,
        input int unsigned os
    );
        return clk_hz / (baud * os);
    endfunction

endpackage

// File: rtl/baud_prescaler.sv
// Prescaler for the baud tick generator: counts 0..div_cur-1, emits a wrap
// pulse, and double-buffers divisor writes so a running period is never cut.
module baud_prescaler
    import baud_tick_gen_pkg::*;
#(
    parameter int unsigned DIV_W   = DIV_W_DEF,
    parameter int unsigned DEF_DIV = calc_div(CLK_HZ_DEF, BAUD_DEF, OVERSAMPLE_DEF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_resync,
    input  logic             i_div_wr,
    input  logic [DIV_W-1:0] i_div_in,
    output logic             o_wrap,
    output logic             o_div_err,
    output logic [DIV_W-1:0] o_div_cur
);

    logic [DIV_W-1:0] r_pcnt;
    logic [DIV_W-1:0] r_div_cur;
    logic [DIV_W-1:0] r_shadow;
    logic             r_div_err;

    logic             w_wr_ok;
    logic             w_wr_bad;
    logic [DIV_W-1:0] w_shadow_nxt;
    logic             w_at_end;
    logic             w_wrap;

    always_comb begin
        w_wr_ok      = i_div_wr && (i_div_in >= DIV_W'(MIN_DIV));
        w_wr_bad     = i_div_wr && (i_div_in <  DIV_W'(MIN_DIV));
        w_shadow_nxt = w_wr_ok ? i_div_in : r_shadow;
        // '>=' rather than '==' so a divisor shrunk while paused below the
        // frozen count still wraps on the next enabled cycle.
        w_at_end     = (r_pcnt >= (r_div_cur - DIV_W'(1)));
        w_wrap       = i_en && !i_resync && w_at_end;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pcnt    <= '0;
            r_div_cur <= DIV_W'(DEF_DIV);
            r_shadow  <= DIV_W'(DEF_DIV);
            r_div_err <= 1'b0;
        end else begin
            r_shadow  <= w_shadow_nxt;
            r_div_err <= w_wr_bad;
            if (i_resync) begin
                r_pcnt    <= '0;
                r_div_cur <= w_shadow_nxt;
            end else if (!i_en) begin
                r_div_cur <= w_shadow_nxt;
            end else if (w_at_end) begin
                r_pcnt    <= '0;
                r_div_cur <= w_shadow_nxt;
            end else begin
                r_pcnt    <= r_pcnt + DIV_W'(1);
            end
        end
    end

    assign o_wrap    = w_wrap;
    assign o_div_err = r_div_err;
    assign o_div_cur = r_div_cur;

endmodule

// File: rtl/baud_tick_gen.sv
// Baud tick generator: oversample and baud strobes plus a 50% duty baud
// clock, with runtime divisor update and phase resync for RX alignment.
module baud_tick_gen
    import baud_tick_gen_pkg::*;
#(
    parameter int unsigned CLK_HZ     = CLK_HZ_DEF,
    parameter int unsigned BAUD       = BAUD_DEF,
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int unsigned DIV_W      = DIV_W_DEF,
    parameter int unsigned DEF_DIV    = calc_div(CLK_HZ, BAUD, OVERSAMPLE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             resync,
    input  logic             div_wr,
    input  logic [DIV_W-1:0] div_in,
    output logic             tick_os,
    output logic             tick_baud,
    output logic             clk_out,
    output logic             div_err,
    output logic [DIV_W-1:0] div_cur
);

    localparam int unsigned OW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    logic [OW-1:0] r_ocnt;
    logic          r_tick_os;
    logic          r_tick_baud;
    logic          r_clk_out;

    logic          w_wrap;
    logic          w_ocnt_last;
    logic          w_ocnt_half;

    baud_prescaler #(
        .DIV_W   (DIV_W),
        .DEF_DIV (DEF_DIV)
    ) u_prescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (en),
        .i_resync  (resync),
        .i_div_wr  (div_wr),
        .i_div_in  (div_in),
        .o_wrap    (w_wrap),
        .o_div_err (div_err),
        .o_div_cur (div_cur)
    );

    always_comb begin
        w_ocnt_last = (r_ocnt == OW'(OVERSAMPLE - 1));
        w_ocnt_half = (r_ocnt == OW'(OVERSAMPLE / 2 - 1));
    end

    // clk_out flips on the same edge that raises tick_os, at mid and end of
    // each baud period, so both halves are exactly OVERSAMPLE/2 ticks long.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ocnt      <= '0;
            r_tick_os   <= 1'b0;
            r_tick_baud <= 1'b0;
            r_clk_out   <= 1'b0;
        end else begin
            r_tick_os   <= w_wrap;
            r_tick_baud <= w_wrap && w_ocnt_last;
            if (resync) begin
                r_ocnt    <= '0;
                r_clk_out <= 1'b0;
            end else if (w_wrap) begin
                r_ocnt <= w_ocnt_last ? '0 : r_ocnt + OW'(1);
                if (w_ocnt_last || w_ocnt_half) begin
                    r_clk_out <= ~r_clk_out;
                end
            end
        end
    end

    assign tick_os   = r_tick_os;
    assign tick_baud = r_tick_baud;
    assign clk_out   = r_clk_out;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Self-checking bench for baud_tick_gen: directed timing scenarios plus a
// randomized run, all compared against a tick-counting reference model.
module tb_baud_tick_gen;

    localparam int unsigned DW  = 16;
    localparam int unsigned OS  = 16;
    localparam int unsigned DEF = 651;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          resync = 1'b0;
    logic          div_wr = 1'b0;
    logic [DW-1:0] div_in = '0;
    logic          tick_os;
    logic          tick_baud;
    logic          clk_out;
    logic          div_err;
    logic [DW-1:0] div_cur;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    bit          chk_on   = 1'b0;

    baud_tick_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .resync    (resync),
        .div_wr    (div_wr),
        .div_in    (div_in),
        .tick_os   (tick_os),
        .tick_baud (tick_baud),
        .clk_out   (clk_out),
        .div_err   (div_err),
        .div_cur   (div_cur)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: elapsed cycles in the current tick period, and the
    // tick index within the baud period; clk_out is high for the second half.
    int unsigned m_elapsed = 0;
    int unsigned m_div     = DEF;
    int unsigned m_shadow  = DEF;
    int unsigned m_tidx    = 0;
    logic        e_tick_os = 1'b0;
    logic        e_tick_baud = 1'b0;
    logic        e_clk_out = 1'b0;
    logic        e_div_err = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_elapsed = 0; m_div = DEF; m_shadow = DEF; m_tidx = 0;
            e_tick_os = 1'b0; e_tick_baud = 1'b0; e_div_err = 1'b0;
        end else begin
            e_div_err   = div_wr && (int'(div_in) < 2);
            if (div_wr && int'(div_in) >= 2) m_shadow = int'(div_in);
            e_tick_os   = 1'b0;
            e_tick_baud = 1'b0;
            if (resync) begin
                m_elapsed = 0; m_tidx = 0; m_div = m_shadow;
            end else if (!en) begin
                m_div = m_shadow;
            end else begin
                m_elapsed++;
                if (m_elapsed >= m_div) begin
                    m_elapsed   = 0;
                    m_div       = m_shadow;
                    m_tidx      = (m_tidx + 1) % OS;
                    e_tick_os   = 1'b1;
                    e_tick_baud = (m_tidx == 0);
                end
            end
        end
        e_clk_out = (m_tidx >= OS / 2);
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check_eq("m_tick_os",   32'(tick_os),   32'(e_tick_os));
            check_eq("m_tick_baud", 32'(tick_baud), 32'(e_tick_baud));
            check_eq("m_clk_out",   32'(clk_out),   32'(e_clk_out));
            check_eq("m_div_err",   32'(div_err),   32'(e_div_err));
            check_eq("m_div_cur",   32'(div_cur),   m_div);
        end
    end

    // Counts falling edges until the selected output reaches lvl (bounded).
    task automatic wait_sig(input int sel, input logic lvl, input int unsigned max,
                            output int unsigned n);
        logic v;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            v = (sel == 0) ? tick_os : (sel == 1) ? tick_baud : clk_out;
        end while (v !== lvl && n < max);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; en = 1'b1; resync = 1'b0; div_wr = 1'b0; div_in = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic write_div(input int unsigned v);
        div_wr = 1'b1;
        div_in = DW'(v);
        @(negedge clk);
        div_wr = 1'b0;
    endtask

    int unsigned n, n_lo, n_hi, seen;

    initial begin
        do_reset();
        check_eq("rst_tick_os",   32'(tick_os),   0);
        check_eq("rst_tick_baud", 32'(tick_baud), 0);
        check_eq("rst_clk_out",   32'(clk_out),   0);
        check_eq("rst_div_err",   32'(div_err),   0);
        check_eq("rst_div_cur",   32'(div_cur),   DEF);
        chk_on = 1'b1;

        // Default rates
        wait_sig(0, 1'b1, 2000, n); check_eq("first_tick", n, DEF);
        for (int i = 0; i < 3; i++) begin
            wait_sig(0, 1'b1, 2000, n); check_eq("tick_period", n, DEF);
        end
        wait_sig(1, 1'b1, 20000, n); check_eq("first_baud", n, 12 * DEF);
        wait_sig(2, 1'b1, 20000, n_lo); check_eq("clk_out_low", n_lo, 8 * DEF);
        wait_sig(2, 1'b0, 20000, n_hi); check_eq("clk_out_high", n_hi, 8 * DEF);
        check_eq("baud_at_fall", 32'(tick_baud), 1);
        check_eq("baud_period", n_lo + n_hi, OS * DEF);

        // Rejected divisor writes
        write_div(1);
        check_eq("err_pulse_1", 32'(div_err), 1);
        @(negedge clk); check_eq("err_clear_1", 32'(div_err), 0);
        write_div(0);
        check_eq("err_pulse_0", 32'(div_err), 1);
        @(negedge clk); check_eq("err_clear_0", 32'(div_err), 0);
        check_eq("err_div_kept", 32'(div_cur), DEF);

        // Mid-period divisor change
        wait_sig(0, 1'b1, 2000, n);
        repeat (200) @(negedge clk);
        write_div(54);
        check_eq("wr54_pending", 32'(div_cur), DEF);
        wait_sig(0, 1'b1, 2000, n); check_eq("wr54_finish", n, DEF - 201);
        check_eq("wr54_cur", 32'(div_cur), 54);
        for (int i = 0; i < 2; i++) begin
            wait_sig(0, 1'b1, 2000, n); check_eq("wr54_period", n, 54);
        end

        // Resync at ocnt=7, pcnt=300
        do_reset();
        for (int i = 0; i < 7; i++) wait_sig(0, 1'b1, 2000, n);
        repeat (300) @(negedge clk);
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        check_eq("rsy_clk_out", 32'(clk_out), 0);
        check_eq("rsy_tick", 32'(tick_os), 0);
        wait_sig(0, 1'b1, 2000, n); check_eq("rsy_next_tick", n, DEF);

        // Enable pause at pcnt=100
        repeat (100) @(negedge clk);
        en = 1'b0;
        seen = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tick_os || tick_baud) seen++;
        end
        check_eq("pause_no_ticks", seen, 0);
        en = 1'b1;
        wait_sig(0, 1'b1, 2000, n); check_eq("pause_resume", n, DEF - 100);

        // Reset one cycle before a due tick, with a pending shadow
        repeat (10) @(negedge clk);
        write_div(54);
        repeat (DEF - 12) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_tick", 32'(tick_os), 0);
        check_eq("rst_mid_div", 32'(div_cur), DEF);
        rst_n = 1'b1;
        wait_sig(0, 1'b1, 2000, n); check_eq("rst_mid_first", n, DEF);

        // Randomized traffic, checked cycle by cycle by the model
        for (int i = 0; i < 30000; i++) begin
            @(negedge clk);
            rst_n  = ($urandom_range(0, 999) != 0);
            en     = ($urandom_range(0, 9) != 0);
            resync = ($urandom_range(0, 199) == 0);
            div_wr = ($urandom_range(0, 49) == 0);
            div_in = DW'($urandom_range(0, 40));
        end
        @(negedge clk);
        rst_n = 1'b1; en = 1'b1; resync = 1'b0; div_wr = 1'b0;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
